// File: rtl/gb_timer_if.sv
// rtl/gb_timer_if.sv - CPU memory-bus bundle between the CPU and the timer responder
interface gb_timer_if;
    logic [15:0] a;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
    logic [7:0]  rdata;
    logic        hit;

    modport master (output a, wdata, rd, wr, input rdata, hit);
    modport slave  (input a, wdata, rd, wr, output rdata, hit);
endinterface

// File: rtl/gb_timer.sv
// rtl/gb_timer.sv - DIV/TIMA/TMA/TAC timer with overflow reload and one-clk interrupt pulse
module gb_timer #(
    parameter logic [15:0] BASE = 16'hFF04
) (
    input  logic        clk,
    input  logic        rst,
    gb_timer_if.slave   bus,
    output logic        irq
);
    typedef enum logic {RUN, OVF} state_e;

    state_e      state_q, state_d;
    logic [15:0] counter_q, counter_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        sig_d_q;
    logic [7:0]  rdata_q, rdata_d;
    logic        hit_q, hit_d;
    logic        irq_q, irq_d;

    logic        sel, div_wr, tima_wr, tma_wr, tac_wr;
    logic        tick_bit, sig, inc;
    logic [7:0]  reg_val;

    assign sel     = (bus.a[15:2] == BASE[15:2]);
    assign div_wr  = bus.wr && sel && (bus.a[1:0] == 2'd0);
    assign tima_wr = bus.wr && sel && (bus.a[1:0] == 2'd1);
    assign tma_wr  = bus.wr && sel && (bus.a[1:0] == 2'd2);
    assign tac_wr  = bus.wr && sel && (bus.a[1:0] == 2'd3);

    always_comb begin
        tick_bit = 1'b0;
        case (tac_q[1:0])
            2'd0: tick_bit = counter_q[9];
            2'd1: tick_bit = counter_q[3];
            2'd2: tick_bit = counter_q[5];
            2'd3: tick_bit = counter_q[7];
            default: tick_bit = 1'b0;
        endcase
    end

    // Falling-edge detect: a DIV clear or TAC change that drops sig also counts.
    assign sig = tac_q[2] & tick_bit;
    assign inc = sig_d_q & ~sig;

    always_comb begin
        reg_val = 8'hFF;
        case (bus.a[1:0])
            2'd0: reg_val = counter_q[15:8];
            2'd1: reg_val = tima_q;
            2'd2: reg_val = tma_q;
            2'd3: reg_val = {5'b11111, tac_q};
            default: reg_val = 8'hFF;
        endcase
    end

    always_comb begin
        counter_d = div_wr ? 16'h0000 : counter_q + 16'h0001;
        tma_d     = tma_wr ? bus.wdata : tma_q;
        tac_d     = tac_wr ? bus.wdata[2:0] : tac_q;
        hit_d     = bus.rd && sel;
        rdata_d   = (bus.rd && sel) ? reg_val : 8'hFF;
    end

    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        irq_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (tima_wr) begin
                    tima_d = bus.wdata;
                end else if (inc) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = OVF;
                    end else begin
                        tima_d = tima_q + 8'h01;
                    end
                end
            end
            OVF: begin
                // A CPU write to TIMA here cancels the pending reload and interrupt.
                state_d = RUN;
                if (tima_wr) begin
                    tima_d = bus.wdata;
                end else begin
                    tima_d = tma_d;
                    irq_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            counter_q <= 16'h0000;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            sig_d_q   <= 1'b0;
            rdata_q   <= 8'hFF;
            hit_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            sig_d_q   <= sig;
            rdata_q   <= rdata_d;
            hit_q     <= hit_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.hit   = hit_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_gb_timer.sv
// tb/tb_gb_timer.sv - scoreboard bench for gb_timer
module tb_gb_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   d0;
    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         irq_log[$];

    always #5 clk = ~clk;

    gb_timer_if bus();

    gb_timer #(.BASE(16'hFF04)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .irq (irq)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin
        string t;
        if (irq === 1'b1) irq_log.push_back(edge_n);
        if (bus.hit === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_hit", 16'd1, 16'd0);
            end else begin
                t = tag_q.pop_front();
                check(t, {8'h00, bus.rdata}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        repeat (n) step();
    endtask

    task automatic bus_wr(input logic [15:0] addr, input logic [7:0] d);
        bus.a = addr; bus.wdata = d; bus.wr = 1'b1; bus.rd = 1'b0;
        step();
        bus.wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] addr, input logic [7:0] e, input string tag);
        bus.a = addr; bus.rd = 1'b1; bus.wr = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        step();
        check({tag, "_hit"}, {15'd0, bus.hit}, 16'd1);
        bus.rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hit"},   {15'd0, bus.hit}, 16'd0);
        check({tag, "_rdata"}, {8'h00, bus.rdata}, 16'h00FF);
        check({tag, "_irq"},   {15'd0, irq}, 16'd0);
    endtask

    function automatic logic [7:0] ovf_exp(input int t);
        if (t <= 17) return 8'hFE;
        if (t <= 33) return 8'hFF;
        if (t == 34) return 8'h00;
        return 8'hF0;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.a = 16'h0000; bus.wdata = 8'h00; bus.rd = 1'b0; bus.wr = 1'b0;

        // Reset held: reads are ignored
        for (int i = 0; i < 4; i++) begin
            bus.a  = 16'hFF04 + 16'(i);
            bus.rd = 1'b1;
            step();
            check_reset_outputs("in_reset");
        end
        bus.rd = 1'b0;
        rst = 1'b1;
        bus_rd(16'hFF07, 8'hF8, "tac_after_rst");
        bus_rd(16'hFF05, 8'h00, "tima_after_rst");
        bus_rd(16'hFF06, 8'h00, "tma_after_rst");
        bus_rd(16'hFF04, 8'h00, "div_after_rst");

        // Register readback
        bus_wr(16'hFF06, 8'h5A);
        bus_wr(16'hFF07, 8'h06);
        bus_rd(16'hFF06, 8'h5A, "tma_rb");
        bus_rd(16'hFF07, 8'hFE, "tac_rb");
        bus.a = 16'hFF08; bus.rd = 1'b1;
        step();
        check("ff08_hit", {15'd0, bus.hit}, 16'd0);
        check("ff08_rdata", {8'h00, bus.rdata}, 16'h00FF);
        bus.rd = 1'b0;
        bus_wr(16'hFF07, 8'h00);

        // Counting with TAC=05: one increment per 16 clk
        bus_wr(16'hFF07, 8'h05);
        bus_wr(16'hFF04, 8'h00);
        d0 = edge_n;
        bus_wr(16'hFF05, 8'h00);
        for (int t = 2; t <= 70; t++)
            bus_rd(16'hFF05, (t > 17) ? 8'((t - 18) / 16 + 1) : 8'h00, "count");
        idle(441);
        bus_rd(16'hFF04, 8'h01, "div_511");
        bus_rd(16'hFF04, 8'h02, "div_512");

        // Overflow and reload from TMA
        irq_log.delete();
        bus_wr(16'hFF06, 8'hF0);
        bus_wr(16'hFF04, 8'h00);
        d0 = edge_n;
        bus_wr(16'hFF05, 8'hFE);
        for (int t = 2; t <= 40; t++) bus_rd(16'hFF05, ovf_exp(t), "ovf");
        check("ovf_irq_count", 16'(irq_log.size()), 16'd1);
        if (irq_log.size() > 0) check("ovf_irq_edge", 16'(irq_log[0] - d0), 16'd34);

        // TMA written on the reload edge is what gets loaded
        irq_log.delete();
        bus_wr(16'hFF04, 8'h00);
        d0 = edge_n;
        bus_wr(16'hFF05, 8'hFE);
        for (int t = 2; t <= 33; t++) bus_rd(16'hFF05, ovf_exp(t), "ovf2");
        bus_wr(16'hFF06, 8'h33);
        bus_rd(16'hFF05, 8'h33, "reload_tma_wr");
        bus_rd(16'hFF06, 8'h33, "tma_after_reload");
        check("ovf2_irq_count", 16'(irq_log.size()), 16'd1);
        if (irq_log.size() > 0) check("ovf2_irq_edge", 16'(irq_log[0] - d0), 16'd34);

        // TIMA write during OVF cancels reload and irq
        irq_log.delete();
        bus_wr(16'hFF04, 8'h00);
        d0 = edge_n;
        bus_wr(16'hFF05, 8'hFE);
        for (int t = 2; t <= 33; t++) bus_rd(16'hFF05, ovf_exp(t), "ovf3");
        bus_wr(16'hFF05, 8'h77);
        for (int t = 35; t <= 52; t++) bus_rd(16'hFF05, (t <= 49) ? 8'h77 : 8'h78, "cancel");
        check("cancel_irq_count", 16'(irq_log.size()), 16'd0);

        // Glitch increments from DIV clear and TAC change
        bus_wr(16'hFF04, 8'h00);
        bus_wr(16'hFF05, 8'h10);
        idle(8);
        bus_wr(16'hFF04, 8'h00);
        bus_rd(16'hFF05, 8'h10, "div_glitch_pre");
        bus_rd(16'hFF05, 8'h11, "div_glitch");
        bus_rd(16'hFF05, 8'h11, "div_glitch_hold");
        idle(6);
        bus_wr(16'hFF07, 8'h01);
        bus_rd(16'hFF05, 8'h11, "tac_glitch_pre");
        bus_rd(16'hFF05, 8'h12, "tac_glitch");
        bus_rd(16'hFF05, 8'h12, "tac_glitch_hold");
        check("glitch_irq_count", 16'(irq_log.size()), 16'd0);

        // Reset while in OVF: no irq, everything back to reset values
        irq_log.delete();
        bus_wr(16'hFF07, 8'h05);
        bus_wr(16'hFF04, 8'h00);
        bus_wr(16'hFF05, 8'hFF);
        idle(16);
        rst = 1'b0;
        #1;
        check_reset_outputs("ovf_rst_now");
        idle(3);
        check_reset_outputs("ovf_rst_held");
        rst = 1'b1;
        idle(3);
        check("ovf_rst_irq_count", 16'(irq_log.size()), 16'd0);
        bus_rd(16'hFF05, 8'h00, "tima_post_rst");
        bus_rd(16'hFF06, 8'h00, "tma_post_rst");
        bus_rd(16'hFF07, 8'hF8, "tac_post_rst");

        idle(2);
        check("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
